// File: rtl/cpu_io_pkg.sv
// Shared types for the CPU serial I/O blocks (receiver now, transmitter later).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_io_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Default oversampling: Clk cycles per serial bit.
  localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
// Latency: 2 Clk cycles from Din to Dout.
// Backpressure: none; Dout follows Din continuously.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Din,
  output logic Dout
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      meta <= RESET_VALUE;
      Dout <= RESET_VALUE;
    end else begin
      meta <= Din;
      Dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver feeding the CPU input port register (Output + Write strobe).
// Latency: Write rises CLKS_PER_BIT/2+(WIDTH_DATA_LENGTH+1)*CLKS_PER_BIT+3 cycles after the start-bit falling edge on Rx.
// Backpressure: none; the port latches Output on the Write strobe and must always accept it.
module uart_rx_port
  import cpu_io_pkg::*;
#(
  parameter int WIDTH_DATA_LENGTH = 8,
  parameter int CLKS_PER_BIT      = DEFAULT_CLKS_PER_BIT
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Rx,
  output logic [WIDTH_DATA_LENGTH-1:0] Output,
  output logic                         Write,
  output logic                         FrameErr,
  output logic                         Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(WIDTH_DATA_LENGTH + 1);

  // Counter terminal values: half a bit to reach mid start bit, a full bit thereafter.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH_DATA_LENGTH - 1);

  logic                         rx_s;
  rx_state_t                    state, state_nxt;
  logic [CNT_W-1:0]             cnt, cnt_nxt;
  logic [IDX_W-1:0]             idx, idx_nxt;
  logic [WIDTH_DATA_LENGTH-1:0] shreg, shreg_nxt;
  logic [WIDTH_DATA_LENGTH-1:0] out_nxt;
  logic                         wr_nxt;
  logic                         fe_nxt;

  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .Clk  (Clk),
    .Rst  (Rst),
    .Din  (Rx),
    .Dout (rx_s)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      Output   <= '0;
      Write    <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      shreg    <= shreg_nxt;
      Output   <= out_nxt;
      Write    <= wr_nxt;
      FrameErr <= fe_nxt;
    end
  end

  // Frame sequencing: every sample point falls on a counter wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    out_nxt   = Output;
    wr_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            // Line back high by mid start bit: glitch, not a frame.
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          // LSB arrives first, so shift right and insert at the top.
          shreg_nxt = {rx_s, shreg[WIDTH_DATA_LENGTH-1:1]};
          if (idx == LAST_IDX) state_nxt = STOP;
          else                 idx_nxt   = idx + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            // Back to IDLE mid stop bit so a following start edge is not missed.
            out_nxt   = shreg;
            wr_nxt    = 1'b1;
            state_nxt = IDLE;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low (break) line must not look like a stream of start bits.
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_port.sv
module tb_uart_rx_port;

  localparam int CPB = 16;
  localparam int W   = 8;
  // Pin fall -> 2 sync flops -> IDLE detect edge, then half bit + 8 data bits + stop bit.
  localparam int LAT = 3 + CPB / 2 + (W + 1) * CPB;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Rx;
  logic [W-1:0] Output;
  logic         Write;
  logic         FrameErr;
  logic         Busy;

  always #5 Clk = ~Clk;

  uart_rx_port #(
    .WIDTH_DATA_LENGTH (W),
    .CLKS_PER_BIT      (CPB)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Rx       (Rx),
    .Output   (Output),
    .Write    (Write),
    .FrameErr (FrameErr),
    .Busy     (Busy)
  );

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Stand-in for the CPU input port register.
  logic [W-1:0] port_q;
  always @(posedge Clk) begin
    if (Rst) port_q <= '0;
    else if (Write) port_q <= Output;
  end

  typedef struct {
    int         at;
    bit         err;
    logic [7:0] data;
    logic       busy;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [7:0] port_hist[int];
  int         n_overlap = 0;
  int         n_consec  = 0;
  logic       prev_pulse = 1'b0;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] model_out = 8'h00;

  // Record every strobe with its cycle and the outputs seen alongside it.
  always @(negedge Clk) begin
    ev_t e;
    port_hist[cyc] = port_q;
    if (Write === 1'b1 || FrameErr === 1'b1) begin
      e.at   = cyc;
      e.err  = (FrameErr === 1'b1);
      e.data = Output;
      e.busy = Busy;
      obs_q.push_back(e);
    end
    if (Write === 1'b1 && FrameErr === 1'b1) n_overlap++;
    if ((Write === 1'b1 || FrameErr === 1'b1) && prev_pulse) n_consec++;
    prev_pulse = (Write === 1'b1 || FrameErr === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int k);
    Rx = 1'b1;
    repeat (k) @(negedge Clk);
  endtask

  // Drive one frame from the current negedge; the model predicts its strobe.
  task automatic send(input logic [7:0] d, input bit stop_ok, input int hold);
    ev_t e;
    e.at  = cyc + LAT;
    e.err = !stop_ok;
    e.busy = !stop_ok;
    if (stop_ok) model_out = d;
    e.data = model_out;
    exp_q.push_back(e);
    Rx = 1'b0;
    repeat (CPB) @(negedge Clk);
    for (int i = 0; i < W; i++) begin
      Rx = d[i];
      repeat (CPB) @(negedge Clk);
    end
    Rx = stop_ok;
    repeat (CPB + hold) @(negedge Clk);
    Rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    chk({tag, "_events"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev_t o;
      ev_t x;
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, "_cycle"}, o.at, x.at);
      chk({tag, "_kind"}, 32'(o.err), 32'(x.err));
      chk({tag, "_data"}, 32'(o.data), 32'(x.data));
      chk({tag, "_busy"}, 32'(o.busy), 32'(x.busy));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int busy_cnt;
    int w_at;
    logic [7:0] d;
    bit ok;

    // Reset state.
    Rst = 1'b1;
    Rx  = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_output", 32'(Output), 0);
    chk("rst_write", 32'(Write), 0);
    chk("rst_frameerr", 32'(FrameErr), 0);
    chk("rst_busy", 32'(Busy), 0);
    Rst = 1'b0;
    idle(10);

    // Single good frame.
    send(8'hA5, 1'b1, 0);
    idle(20);
    drain("frame_a5");

    // Glitch shorter than half a bit: no strobe, Busy for exactly half a bit.
    busy_cnt = 0;
    Rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) Rx = 1'b1;
      @(negedge Clk);
      if (Busy === 1'b1) busy_cnt++;
    end
    chk("false_start_busy_cycles", busy_cnt, CPB / 2);
    idle(10);
    drain("false_start");

    // Bad stop bit followed by a long low line.
    send(8'h3C, 1'b0, 40);
    chk("break_busy_at_release", 32'(Busy), 1);
    @(negedge Clk);
    chk("break_busy_after_1", 32'(Busy), 1);
    repeat (3) @(negedge Clk);
    chk("break_busy_after_4", 32'(Busy), 0);
    idle(20);
    drain("frame_err");

    // Back-to-back frames, no idle gap.
    send(8'h00, 1'b1, 0);
    send(8'hFF, 1'b1, 0);
    idle(20);
    drain("back_to_back");

    // Reset in the middle of data bit 4; the sender abandons the frame.
    d = 8'h5A;
    Rx = 1'b0;
    repeat (CPB) @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      Rx = d[i];
      repeat (CPB) @(negedge Clk);
    end
    Rx = d[4];
    repeat (CPB / 2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("midrst_output", 32'(Output), 0);
    chk("midrst_write", 32'(Write), 0);
    chk("midrst_frameerr", 32'(FrameErr), 0);
    chk("midrst_busy", 32'(Busy), 0);
    model_out = 8'h00;
    idle(40);
    drain("mid_reset");
    send(8'h81, 1'b1, 0);
    idle(20);
    drain("after_reset");

    // Port register picks up the byte on the edge after Write.
    w_at = cyc + LAT;
    send(8'h7E, 1'b1, 0);
    idle(5);
    chk("port_during_write", 32'(port_hist[w_at]), 32'h81);
    chk("port_after_write", 32'(port_hist[w_at + 1]), 32'h7E);
    drain("port_7e");

    // Random frames, gaps and framing errors.
    for (int k = 0; k < 8; k++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send(d, ok, ok ? 0 : int'($urandom_range(1, 30)));
      idle(ok ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12)));
    end
    idle(20);
    drain("random");

    chk("write_fe_overlap", n_overlap, 0);
    chk("strobe_consecutive", n_consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
